cache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the processor and
//  the 128-bit handshake memory. Hits serve in the same cycle without a stall.

---
 rtl/cache_pkg.sv | 41 ++++
 rtl/cache_line_array.sv | 65 ++++++
 rtl/cache.sv | 143 ++++++++++++++
 tb/tb_cache.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// The processor word address is split as {tag, index, offset}.
package cache_pkg;

    localparam int NUM_BLOCKS = 8;
    localparam int WORD_W     = 32;
    localparam int BLK_WORDS  = 4;
    localparam int ADDR_W     = 30;
    localparam int MEM_ADDR_W = 28;

    localparam int IDX_W  = $clog2(NUM_BLOCKS);
    localparam int OFF_W  = $clog2(BLK_WORDS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = WORD_W * BLK_WORDS;

    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [OFF_W-1:0]      off_t;
    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [MEM_ADDR_W-1:0] blk_addr_t;

    // Word 0 occupies the least significant lane, matching the memory bus layout.
    typedef logic [BLK_WORDS-1:0][WORD_W-1:0] line_t;

    typedef struct packed {
        tag_t tag;
        idx_t idx;
        off_t off;
    } addr_t;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    function automatic blk_addr_t blk_of(input tag_t tag, input idx_t idx);
        return {tag, idx};
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty/tag/data per index, asynchronous read, one synchronous
// write port that either updates a single word (hit) or fills a whole line (refill).
module cache_line_array
    import cache_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  idx_t  rd_idx,
    output logic  rd_valid,
    output logic  rd_dirty,
    output tag_t  rd_tag,
    output line_t rd_line,
    input  logic  word_we,
    input  logic  fill_we,
    input  idx_t  wr_idx,
    input  off_t  wr_off,
    input  word_t wr_word,
    input  tag_t  fill_tag,
    input  line_t fill_line
);

    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    tag_t                  tag_q  [NUM_BLOCKS];
    line_t                 data_q [NUM_BLOCKS];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_we) begin
            valid_d[wr_idx] = 1'b1;
            dirty_d[wr_idx] = 1'b0;
        end else if (word_we) begin
            dirty_d[wr_idx] = 1'b1;
        end
    end

    // NOTE: sequential state is assigned with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // NOTE: tag and data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[wr_idx]  <= fill_tag;
            data_q[wr_idx] <= fill_line;
        end else if (word_we) begin
            data_q[wr_idx][wr_off] <= wr_word;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete combinationally;
// misses stall the processor while a write-back and/or refill runs on the memory handshake.
module cache
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  proc_reset,
    input  logic                  proc_read,
    input  logic                  proc_write,
    input  logic [ADDR_W-1:0]     proc_addr,
    input  logic [WORD_W-1:0]     proc_wdata,
    output logic [WORD_W-1:0]     proc_rdata,
    output logic                  proc_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    state_e    state_q, state_d;
    logic      mem_read_q, mem_read_d;
    logic      mem_write_q, mem_write_d;
    blk_addr_t mem_addr_q, mem_addr_d;
    line_t     mem_wdata_q, mem_wdata_d;
    logic      armed_q, armed_d;
    blk_addr_t miss_blk_q, miss_blk_d;

    addr_t pa;
    logic  rd_valid, rd_dirty;
    tag_t  rd_tag;
    line_t rd_line;
    logic  req, hit, ready_ok;
    logic  word_we, fill_we;
    idx_t  wr_idx;

    assign pa       = addr_t'(proc_addr);
    assign req      = proc_read | proc_write;
    assign hit      = rd_valid & (rd_tag == pa.tag);
    // A ready that was already high when the request went out belongs to the previous transaction.
    assign ready_ok = mem_ready & armed_q;
    assign wr_idx   = fill_we ? miss_blk_q[IDX_W-1:0] : pa.idx;

    cache_line_array u_lines (
        .clk       (clk),
        .rst       (proc_reset),
        .rd_idx    (pa.idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .fill_we   (fill_we),
        .wr_idx    (wr_idx),
        .wr_off    (pa.off),
        .wr_word   (proc_wdata),
        .fill_tag  (miss_blk_q[MEM_ADDR_W-1:IDX_W]),
        .fill_line (line_t'(mem_rdata))
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= ST_COMPARE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            armed_q     <= 1'b0;
            miss_blk_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            armed_q     <= armed_d;
            miss_blk_q  <= miss_blk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        armed_d     = armed_q;
        miss_blk_d  = miss_blk_q;
        case (state_q)
            ST_COMPARE: begin
                if (req && !hit) begin
                    miss_blk_d = blk_of(pa.tag, pa.idx);
                    armed_d    = 1'b0;
                    if (rd_valid && rd_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = blk_of(rd_tag, pa.idx);
                        mem_wdata_d = rd_line;
                        state_d     = ST_WRITEBACK;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = blk_of(pa.tag, pa.idx);
                        state_d    = ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (ready_ok) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = miss_blk_q;
                    armed_d     = 1'b0;
                    state_d     = ST_ALLOCATE;
                end else if (!mem_ready) begin
                    armed_d = 1'b1;
                end
            end
            ST_ALLOCATE: begin
                if (ready_ok) begin
                    mem_read_d = 1'b0;
                    state_d    = ST_COMPARE;
                end else if (!mem_ready) begin
                    armed_d = 1'b1;
                end
            end
            default: state_d = ST_COMPARE;
        endcase
    end

    // A simultaneous read and write is served as a read; the write is dropped.
    always_comb begin
        proc_stall = req & ~((state_q == ST_COMPARE) & hit);
        proc_rdata = proc_read ? rd_line[pa.off] : '0;
        word_we    = (state_q == ST_COMPARE) & hit & proc_write & ~proc_read;
        fill_we    = (state_q == ST_ALLOCATE) & ready_ok;
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cache.sv
// Bench for cache: handshake memory model with stale ready, word-level reference model,
// hit/miss model over tags, and a scoreboard monitor comparing every serviced read.
module tb_cache;
    import cache_pkg::*;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          proc_read, proc_write;
    logic [29:0]   proc_addr;
    logic [31:0]   proc_wdata, proc_rdata;
    logic          proc_stall;
    logic          mem_read, mem_write, mem_ready;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory side ----------------
    typedef struct {
        bit           is_wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } txn_t;

    logic [127:0] mem_blk [logic [27:0]];
    txn_t         mem_log [$];

    function automatic logic [31:0] word_init(input logic [29:0] wa);
        return {wa, 2'b11} ^ 32'h5A00_0000;
    endfunction

    function automatic logic [127:0] blk_read(input logic [27:0] a);
        logic [127:0] r;
        logic [1:0]   w2;
        if (mem_blk.exists(a)) return mem_blk[a];
        for (int w = 0; w < 4; w++) begin
            w2 = 2'(w);
            r[w*32 +: 32] = word_init({a, w2});
        end
        return r;
    endfunction

    // Ready stays high for two posedges, so the first one of the next request sees it stale.
    task automatic mem_serve();
        bit           is_wr, ok;
        logic [27:0]  a;
        logic [127:0] wd;
        int           lat;
        is_wr = mem_write;
        a     = mem_addr;
        wd    = mem_wdata;
        mem_log.push_back('{is_wr, a, wd});
        lat = $urandom_range(1, 4);
        ok  = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (proc_reset || !(mem_read || mem_write)) ok = 1'b0;
        end
        if (!ok) return;
        if (is_wr) begin
            mem_blk[a] = wd;
            mem_rdata  = wd;
        end else begin
            mem_rdata = blk_read(a);
        end
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
    endtask

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!proc_reset && (mem_read || mem_write)) mem_serve();
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_word [logic [29:0]];
    bit          ref_valid [8];
    logic [24:0] ref_tag   [8];
    logic [31:0] exp_q [$];

    function automatic logic [31:0] ref_read(input logic [29:0] a);
        return ref_word.exists(a) ? ref_word[a] : word_init(a);
    endfunction

    // Scoreboard monitor: every serviced read pops one expectation.
    initial forever begin
        @(negedge clk);
        #2;
        if (!proc_reset && proc_read && !proc_stall) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rdata: got %0h with no read outstanding, expected none", proc_rdata);
            end else begin
                check("rdata", proc_rdata, exp_q.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (mem_read && mem_write) begin
            compared++;
            mismatched++;
            $display("FAIL mem_excl: got mem_read=1 mem_write=1, expected at most one high");
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no completion by 1ms, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic wait_served(output int cyc, output bit ok);
        cyc = 0;
        #1;
        while (proc_stall && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        ok = !proc_stall;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL serve_timeout: got stall after %0d cycles, expected service", cyc);
        end
    endtask

    task automatic release_req();
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, output int cyc);
        bit          exp_hit, ok;
        int          idx;
        logic [24:0] t;
        t       = a[29:5];
        idx     = int'(a[4:2]);
        exp_hit = ref_valid[idx] && (ref_tag[idx] == t);
        @(negedge clk);
        if (rd) exp_q.push_back(ref_read(a));
        else if (wr) ref_word[a] = wd;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        wait_served(cyc, ok);
        if (ok) begin
            check("hit_no_stall", 128'(cyc == 0), 128'(exp_hit));
        end else if (rd) begin
            void'(exp_q.pop_back());
        end
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = t;
        release_req();
    endtask

    initial begin
        int          cyc, misses;
        bit          ok, rd, wr;
        logic [29:0] a;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_stall_idle", proc_stall, 0);
        @(negedge clk);
        proc_reset = 1'b0;

        // Test 1: compulsory miss on word 0x10
        @(negedge clk);
        exp_q.push_back(word_init(30'h10));
        proc_read = 1'b1;
        proc_addr = 30'h10;
        #1;
        check("t1_stall", proc_stall, 1);
        @(negedge clk);
        #1;
        check("t1_mem_read", mem_read, 1);
        check("t1_mem_write", mem_write, 0);
        check("t1_mem_addr", mem_addr, 28'h4);
        wait_served(cyc, ok);
        if (!ok) void'(exp_q.pop_back());
        ref_valid[4] = 1'b1;
        ref_tag[4]   = '0;
        release_req();

        // Test 2: write hit then read hit
        do_req(1'b0, 1'b1, 30'h11, 32'hDEAD_BEEF, cyc);
        do_req(1'b1, 1'b0, 30'h11, 32'h0, cyc);

        // Tests 3/4: dirty conflict -> write-back then refill past a stale ready
        mem_log.delete();
        do_req(1'b1, 1'b0, 30'h210, 32'h0, cyc);
        check("t3_txn_count", mem_log.size(), 2);
        if (mem_log.size() >= 2) begin
            check("t3_wb_is_wr", mem_log[0].is_wr, 1);
            check("t3_wb_addr", mem_log[0].addr, 28'h4);
            check("t3_wb_word1", mem_log[0].wdata[63:32], 32'hDEAD_BEEF);
            check("t3_wb_word0", mem_log[0].wdata[31:0], word_init(30'h10));
            check("t3_alloc_is_wr", mem_log[1].is_wr, 0);
            check("t3_alloc_addr", mem_log[1].addr, 28'h84);
        end
        check("t3_mem_blk4_word1", blk_read(28'h4) >> 32, 128'(32'hDEAD_BEEF) | (blk_read(28'h4) >> 64) << 32);
        for (int w = 1; w < 4; w++) do_req(1'b1, 1'b0, 30'h210 + 30'(w), 32'h0, cyc);

        // Test 5: reset in the middle of an allocate
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h410;
        cyc = 0;
        #1;
        while (!mem_read && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("t5_alloc_seen", mem_read, 1);
        check("t5_no_writeback", mem_write, 0);
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        #1;
        check("t5_rst_mem_read", mem_read, 0);
        check("t5_rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        proc_reset = 1'b0;
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        do_req(1'b1, 1'b0, 30'h410, 32'h0, cyc);
        check("t5_miss_after_reset", 128'(cyc > 0), 1);

        // Test 6: index sweep, two passes of write/read
        misses = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                a = {25'h15, 3'(i), 2'(i)};
                do_req(1'b0, 1'b1, a, $urandom, cyc);
                if (cyc > 0) misses++;
                do_req(1'b1, 1'b0, a, 32'h0, cyc);
                if (cyc > 0) misses++;
            end
        end
        check("t6_compulsory_misses", misses, 8);

        // Randomized traffic over a few conflicting tags
        for (int n = 0; n < 300; n++) begin
            a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 2))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            do_req(rd, wr, a, $urandom, cyc);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
